// File: rtl/uart_cmd_frame_decoder.sv
// Byte-stream to command-frame decoder: finds the 55/AA header, collects CODE and four
// parameter bytes, and releases them to the mux only when the additive checksum matches.
module uart_cmd_frame_decoder #(
  parameter logic [7:0]  HDR0           = 8'h55,
  parameter logic [7:0]  HDR1           = 8'hAA,
  parameter int unsigned TIMEOUT_CYCLES = 32'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_data_vaild,
  output logic        cmd_vaild,
  output logic [7:0]  cmd_code,
  output logic [31:0] para_list,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic        busy
);

  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_CODE = 3'd2,
    ST_PARA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    csum_add = acc + b;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (v == 8'hFF) ? 8'hFF : (v + 8'd1);
  endfunction

  state_t           state_r, state_nxt_s;
  logic [7:0]       code_sh_r, code_sh_nxt_s;
  logic [31:0]      para_sh_r, para_sh_nxt_s;
  logic [7:0]       csum_r, csum_nxt_s;
  logic [1:0]       idx_r, idx_nxt_s;
  logic [GAP_W-1:0] gap_r, gap_nxt_s;
  logic             cmd_vaild_r, cmd_vaild_nxt_s;
  logic             frame_err_r, frame_err_nxt_s;
  logic [7:0]       cmd_code_r, cmd_code_nxt_s;
  logic [31:0]      para_list_r, para_list_nxt_s;
  logic [7:0]       err_cnt_r, err_cnt_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             timeout_s;

  // A byte on the expiry cycle takes priority, so timeout requires no strobe.
  assign timeout_s = (state_r != ST_IDLE) && !rx_data_vaild && (gap_r == GAP_LIMIT);

  // Next-state and next-value logic for the frame FSM and its datapath.
  always_comb begin
    state_nxt_s     = state_r;
    code_sh_nxt_s   = code_sh_r;
    para_sh_nxt_s   = para_sh_r;
    csum_nxt_s      = csum_r;
    idx_nxt_s       = idx_r;
    gap_nxt_s       = gap_r;
    cmd_vaild_nxt_s = 1'b0;
    frame_err_nxt_s = 1'b0;
    cmd_code_nxt_s  = cmd_code_r;
    para_list_nxt_s = para_list_r;

    if (timeout_s) begin
      state_nxt_s     = ST_IDLE;
      frame_err_nxt_s = 1'b1;
      gap_nxt_s       = {GAP_W{1'b0}};
    end else if (rx_data_vaild) begin
      gap_nxt_s = {GAP_W{1'b0}};
      case (state_r)
        ST_IDLE: begin
          if (rx_data == HDR0) begin
            state_nxt_s = ST_HDR;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (rx_data == HDR1) begin
            state_nxt_s = ST_CODE;
          end else if (rx_data == HDR0) begin
            state_nxt_s = ST_HDR;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_CODE: begin
          code_sh_nxt_s = rx_data;
          csum_nxt_s    = rx_data;
          idx_nxt_s     = 2'd0;
          state_nxt_s   = ST_PARA;
        end
        ST_PARA: begin
          para_sh_nxt_s = {para_sh_r[23:0], rx_data};
          csum_nxt_s    = csum_add(csum_r, rx_data);
          if (idx_r == 2'd3) begin
            state_nxt_s = ST_CSUM;
          end else begin
            idx_nxt_s   = idx_r + 2'd1;
            state_nxt_s = ST_PARA;
          end
        end
        ST_CSUM: begin
          if (rx_data == csum_r) begin
            cmd_vaild_nxt_s = 1'b1;
            cmd_code_nxt_s  = code_sh_r;
            para_list_nxt_s = para_sh_r;
          end else begin
            frame_err_nxt_s = 1'b1;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else if (state_r == ST_IDLE) begin
      gap_nxt_s = {GAP_W{1'b0}};
    end else begin
      gap_nxt_s = gap_r + GAP_W'(1);
    end

    err_cnt_nxt_s = frame_err_nxt_s ? sat_inc8(err_cnt_r) : err_cnt_r;
    busy_nxt_s    = (state_nxt_s != ST_IDLE);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Datapath and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_sh_r   <= 8'h00;
      para_sh_r   <= 32'h0000_0000;
      csum_r      <= 8'h00;
      idx_r       <= 2'd0;
      gap_r       <= {GAP_W{1'b0}};
      cmd_vaild_r <= 1'b0;
      frame_err_r <= 1'b0;
      cmd_code_r  <= 8'h00;
      para_list_r <= 32'h0000_0000;
      err_cnt_r   <= 8'h00;
      busy_r      <= 1'b0;
    end else begin
      code_sh_r   <= code_sh_nxt_s;
      para_sh_r   <= para_sh_nxt_s;
      csum_r      <= csum_nxt_s;
      idx_r       <= idx_nxt_s;
      gap_r       <= gap_nxt_s;
      cmd_vaild_r <= cmd_vaild_nxt_s;
      frame_err_r <= frame_err_nxt_s;
      cmd_code_r  <= cmd_code_nxt_s;
      para_list_r <= para_list_nxt_s;
      err_cnt_r   <= err_cnt_nxt_s;
      busy_r      <= busy_nxt_s;
    end
  end

  assign cmd_vaild = cmd_vaild_r;
  assign frame_err = frame_err_r;
  assign cmd_code  = cmd_code_r;
  assign para_list = para_list_r;
  assign err_cnt   = err_cnt_r;
  assign busy      = busy_r;

endmodule

// File: doc/uart_cmd_frame_decoder.md
# uart_cmd_frame_decoder

Decodes bytes from the UART receiver into validated command frames for the display-mode mux control. It locates a two-byte header, captures a command code and a 32-bit parameter list, and checks an additive checksum. Each valid frame produces a one-cycle `cmd_vaild` strobe, with `cmd_code` and `para_list` updated on that same cycle. It sits between the UART RX byte interface and the mux command input port.

## Interface
- `HDR0`, default 8'h55: first header byte.
- `HDR1`, default 8'hAA: second header byte.
- `TIMEOUT_CYCLES`, default 50000: maximum allowed clk gap between bytes inside a frame. Minimum value 2.
- `clk`  in  1: system clock.
- `rst`  in  1: reset, synchronous and active-high.
- `rx_data`  in  8: received byte.
- `rx_data_vaild`  in  1: one-cycle strobe that qualifies `rx_data`.
- `cmd_vaild`  out  1: one-cycle pulse for an accepted frame.
- `cmd_code`  out  8: code of the last accepted frame. Held between frames.
- `para_list`  out  32: parameters of the last accepted frame. Held between frames.
- `frame_err`  out  1: one-cycle pulse on a checksum failure or a timeout.
- `err_cnt`  out  8: saturating count of `frame_err` pulses.
- `busy`  out  1: high whenever the FSM is not in IDLE.

## Operation
- The frame is 8 bytes, in this order: `HDR0`, `HDR1`, CODE, P3, P2, P1, P0, CSUM.
- The parameters are assembled as `para_list = {P3,P2,P1,P0}`, most significant byte first.
- The checksum is `CSUM == (CODE+P3+P2+P1+P0) mod 256`. It is accumulated in an 8-bit register and carries are discarded.
- CODE is not range-checked. Interpreting the code is the consumer's job.
- FSM states and transitions:
  - IDLE: a byte equal to `HDR0` moves to HDR. Any other byte is ignored.
  - HDR: a byte equal to `HDR1` moves to CODE. A byte equal to `HDR0` stays in HDR (resync). Any other byte returns to IDLE with no error.
  - CODE: latch the byte into the shadow code register and initialise the checksum to that byte. Move to PARA with the byte index at 0.
  - PARA: shift each byte into the shadow parameter register and add it to the checksum. After the 4th byte (index 3), move to CSUM.
  - CSUM: on a match, copy the shadow registers to `cmd_code`/`para_list` and pulse `cmd_vaild`. On a mismatch, pulse `frame_err` and leave the outputs unchanged. Either way, return to IDLE.
- Timeout:
  - The gap counter clears on every `rx_data_vaild` and is held at 0 in IDLE.
  - In any state other than IDLE, reaching `TIMEOUT_CYCLES` cycles with no byte forces IDLE and pulses `frame_err`.
  - If a byte and the timeout fall on the same cycle, the byte wins and is processed normally.
- `err_cnt` increments on each `frame_err` pulse and saturates at 8'hFF.
- Bytes that arrive while `rx_data_vaild` is low are ignored.

## Timing
- Reset values:
  - FSM = IDLE.
  - `cmd_vaild` = 0, `frame_err` = 0, `busy` = 0.
  - `cmd_code` = 8'h00, `para_list` = 32'h0, `err_cnt` = 8'h00.
  - Shadow registers, checksum and gap counter = 0.
- Latency: `cmd_vaild` is high on the cycle after the clk edge that samples the CSUM strobe. `cmd_code` and `para_list` take their new values on that same cycle.
- `frame_err` timing:
  - Checksum failure: `frame_err` has the same latency as `cmd_vaild`.
  - Timeout: `frame_err` is high on the cycle after the counter reaches `TIMEOUT_CYCLES`.
- `cmd_vaild` and `frame_err` are never high in the same cycle. Each is exactly 1 cycle wide.
- Back-to-back frames need no idle cycles. A `HDR0` strobe on the cycle right after CSUM is accepted.
- `busy` is registered. It rises the cycle after the `HDR0` strobe and falls on the cycle `cmd_vaild` or `frame_err` is asserted, or when HDR returns to IDLE.
- Reset mid-frame: on the next edge everything returns to the reset values, and the partial frame is discarded without pulsing `frame_err`. The outputs that normally hold (`cmd_code`, `para_list`, `err_cnt`) also clear.
- `rx_data_vaild` may strobe on consecutive cycles. The block accepts one byte per clk.

## Test plan
- Valid frame:
  - Stimulus: 55 AA A1 00 FF 00 FF FE. The checksum is A1+00+FF+00+FF = 0x29F, so CSUM 9F is correct, while FE is wrong. Send the frame once with FE, then again with 9F.
  - Response to the FE frame: one `frame_err` pulse, `err_cnt` = 1, `cmd_code` and `para_list` still 0.
  - Response to the 9F frame: one `cmd_vaild` pulse, `cmd_code` = A1, `para_list` = 32'h00FF00FF.
- Resync:
  - Stimulus: 55 55 AA A0 00 00 00 10 B0.
  - Response: `cmd_vaild` pulses, `cmd_code` = A0, `para_list` = 32'h10. Then send 55 12 and confirm a return to IDLE with no error.
- Timeout:
  - Stimulus: with `TIMEOUT_CYCLES` = 16, send 55 AA A2, then no bytes for 16 cycles.
  - Response: `frame_err` pulses exactly once and `busy` falls. A following full valid frame is still accepted.
- Timeout tie:
  - Stimulus: a byte strobe on exactly the cycle the counter reaches `TIMEOUT_CYCLES`.
  - Response: no `frame_err`, and the frame completes normally.
- Back-to-back frames and saturation:
  - Stimulus: two valid frames with no gap (codes A0, then A2).
  - Response: two `cmd_vaild` pulses 8 cycles apart, with the outputs tracking each frame.
  - Stimulus: 300 bad-checksum frames. Response: `err_cnt` = FF.
- Reset mid-frame:
  - Stimulus: assert `rst` after 55 AA A1 00, then send a full valid frame.
  - Response: the first frame is discarded, the outputs are zeroed, and the new frame decodes correctly.
